// File: rtl/aes_pkg.sv
// rtl/aes_pkg.sv - shared AES constants, FSM encoding and GF(2^8) doubling
package aes_pkg;

  localparam int NB_BYTES = 16;
  localparam int NR       = 10;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    LOAD  = 2'd1,
    READY = 2'd2
  } ark_state_t;

  // Multiply by x in GF(2^8), reduction polynomial 0x11B.
  function automatic logic [7:0] xtime(input logic [7:0] b);
    return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
  endfunction

endpackage

// File: rtl/ark_key_schedule_if.sv
// rtl/ark_key_schedule_if.sv - byte stream and status bundle of the AddRoundKey stage
interface ark_key_schedule_if;
  logic [7:0] key_in;
  logic       key_valid;
  logic [7:0] data_in;
  logic       data_valid;
  logic [7:0] data_out;
  logic       data_out_valid;
  logic [3:0] round;
  logic       key_ready;
  logic       round_done;
  logic       block_done;

  modport master (
    output key_in, key_valid, data_in, data_valid,
    input  data_out, data_out_valid, round, key_ready, round_done, block_done
  );

  modport slave (
    input  key_in, key_valid, data_in, data_valid,
    output data_out, data_out_valid, round, key_ready, round_done, block_done
  );
endinterface

// File: rtl/sub_bytes.sv
// rtl/sub_bytes.sv - single AES S-box, mode 0 forward, mode 1 inverse
module sub_bytes
  import aes_pkg::*;
(
  input  logic       mode,
  input  logic [7:0] din,
  output logic [7:0] dout
);

  function automatic logic [7:0] gf_mul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p;
    logic [7:0] x;
    p = 8'h00;
    x = a;
    for (int i = 0; i < 8; i++) begin
      if (b[i]) p = p ^ x;
      x = xtime(x);
    end
    return p;
  endfunction

  // a^254 is the multiplicative inverse; 0 maps to 0 as AES requires.
  function automatic logic [7:0] gf_inv(input logic [7:0] a);
    logic [7:0] p;
    logic [7:0] r;
    p = a;
    r = 8'h01;
    for (int i = 1; i < 8; i++) begin
      p = gf_mul(p, p);
      r = gf_mul(r, p);
    end
    return r;
  endfunction

  function automatic logic [7:0] rotl(input logic [7:0] v, input int n);
    return (v << n) | (v >> (8 - n));
  endfunction

  logic [7:0] inv_fwd;

  // Forward: inverse then affine; inverse: inverse affine then inverse.
  always_comb begin
    inv_fwd = gf_inv(din);
    if (mode)
      dout = gf_inv(rotl(din, 1) ^ rotl(din, 3) ^ rotl(din, 6) ^ 8'h05);
    else
      dout = inv_fwd ^ rotl(inv_fwd, 1) ^ rotl(inv_fwd, 2) ^ rotl(inv_fwd, 3)
           ^ rotl(inv_fwd, 4) ^ 8'h63;
  end

endmodule

// File: rtl/ark_key_schedule.sv
// rtl/ark_key_schedule.sv - byte-serial AddRoundKey with in-place AES-128 key expansion
module ark_key_schedule #(
  parameter bit KEEP_KEY = 1'b1,
  parameter int NR       = aes_pkg::NR
) (
  input  logic                 clk,
  input  logic                 rst,
  ark_key_schedule_if.slave    bus
);
  import aes_pkg::*;

  localparam logic [3:0] LAST_ROUND = 4'(NR);

  ark_state_t state_q, state_d;
  logic [7:0] key_q [NB_BYTES];
  logic [7:0] bak_q [NB_BYTES];
  logic [3:0] idx_q;
  logic [7:0] rcon_q;
  logic [3:0] round_q;

  logic       key_wr;
  logic [3:0] key_addr;
  logic       data_beat;
  logic       round_end;
  logic       block_end;
  logic [7:0] sbox_in;
  logic [7:0] sbox_out;
  logic [7:0] next_byte;

  // State register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state_q <= IDLE;
    else     state_q <= state_d;
  end

  // Next state and beat qualification; a key byte always wins over data.
  always_comb begin
    state_d   = state_q;
    key_wr    = 1'b0;
    key_addr  = idx_q;
    data_beat = 1'b0;
    case (state_q)
      IDLE: begin
        if (bus.key_valid) begin
          key_wr   = 1'b1;
          key_addr = 4'd0;
          state_d  = LOAD;
        end
      end
      LOAD: begin
        if (bus.key_valid) begin
          key_wr = 1'b1;
          if (idx_q == 4'd15) state_d = READY;
        end
      end
      READY: begin
        if (bus.key_valid) begin
          key_wr   = 1'b1;
          key_addr = 4'd0;
          state_d  = LOAD;
        end else if (bus.data_valid) begin
          data_beat = 1'b1;
          if (idx_q == 4'd15 && round_q == LAST_ROUND && !KEEP_KEY) state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
    round_end = data_beat && (idx_q == 4'd15);
    block_end = round_end && (round_q == LAST_ROUND);
  end

  // Column 3 is untouched while bytes 0..3 are rewritten, so it feeds RotWord/SubWord.
  assign sbox_in = key_q[{2'b11, idx_q[1:0] + 2'd1}];

  sub_bytes u_sbox (
    .mode (1'b0),
    .din  (sbox_in),
    .dout (sbox_out)
  );

  // Byte i of the next round key; bytes 4..15 use the already-updated byte i-4.
  always_comb begin
    if (idx_q[3:2] == 2'b00)
      next_byte = key_q[idx_q] ^ sbox_out ^ ((idx_q == 4'd0) ? rcon_q : 8'h00);
    else
      next_byte = key_q[idx_q] ^ key_q[idx_q - 4'd4];
  end

  generate
    if (KEEP_KEY) begin : g_backup
      // Pristine cipher key, restored after the last round.
      always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
          for (int i = 0; i < NB_BYTES; i++) bak_q[i] <= 8'h00;
        end else if (key_wr) begin
          bak_q[key_addr] <= bus.key_in;
        end
      end
    end else begin : g_no_backup
      // No backup copy; the key is reloaded for every block.
      always_comb begin
        for (int i = 0; i < NB_BYTES; i++) bak_q[i] = 8'h00;
      end
    end
  endgenerate

  // Round-key storage, byte pointer, round counter and round constant.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < NB_BYTES; i++) key_q[i] <= 8'h00;
      idx_q   <= 4'd0;
      rcon_q  <= 8'h01;
      round_q <= 4'd0;
    end else if (key_wr) begin
      key_q[key_addr] <= bus.key_in;
      idx_q           <= key_addr + 4'd1;
      rcon_q          <= 8'h01;
      round_q         <= 4'd0;
    end else if (data_beat) begin
      key_q[idx_q] <= next_byte;
      idx_q        <= idx_q + 4'd1;
      if (block_end) begin
        round_q <= 4'd0;
        rcon_q  <= 8'h01;
        if (KEEP_KEY) begin
          for (int i = 0; i < NB_BYTES; i++) key_q[i] <= bak_q[i];
        end
      end else if (round_end) begin
        round_q <= round_q + 4'd1;
        rcon_q  <= xtime(rcon_q);
      end
    end
  end

  // Registered output byte and its strobes, one cycle after the accepted beat.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      bus.data_out       <= 8'h00;
      bus.data_out_valid <= 1'b0;
      bus.round_done     <= 1'b0;
      bus.block_done     <= 1'b0;
    end else begin
      bus.data_out_valid <= data_beat;
      bus.round_done     <= round_end;
      bus.block_done     <= block_end;
      if (data_beat) bus.data_out <= bus.data_in ^ key_q[idx_q];
    end
  end

  assign bus.round     = round_q;
  assign bus.key_ready = (state_q == READY);

endmodule

// File: doc/ark_key_schedule.md
Name: ark_key_schedule

Overview:
Byte-serial AES-128 AddRoundKey stage with an on-the-fly key schedule. It sits directly downstream of the byte-serial round datapath (permutation -> sbox -> mix-column -> parallel-to-serial). Each state byte that datapath emits is XORed with the matching round-key byte. The next round key is computed in place, one byte per beat, through a single shared S-box instance, which keeps area low.

Parameters:
KEEP_KEY, 1, 1 = keep a backup copy of the cipher key and restore it after round 10; 0 = key must be reloaded for every block (saves 128 flops).
NR, 10, last round index (AES-128).

Ports:
clk  input  1  clock
rst  input  1  reset, asynchronous, active-high
key_in  input  8  cipher-key byte, byte 0 first (column-major, FIPS-197 order)
key_valid  input  1  key_in valid this cycle
data_in  input  8  state byte from the round datapath, byte 0 first
data_valid  input  1  data_in valid this cycle
data_out  output  8  data_in XOR round-key byte, registered
data_out_valid  output  1  data_out valid
round  output  4  index of the round key currently applied (0..NR)
key_ready  output  1  high in state READY
round_done  output  1  one-cycle pulse with the 16th output byte of each round
block_done  output  1  one-cycle pulse with the 16th output byte of round NR

Behaviour:
- Storage:
  - K[0..15]: current round-key bytes.
  - B[0..15]: backup copy, present only when KEEP_KEY=1.
  - idx: 4-bit byte pointer.
  - rcon: 8-bit round constant.
- Reset values: K, B = 0; idx = 0; rcon = 0x01; round = 0; state = IDLE; all outputs 0.
- FSM states: IDLE, LOAD, READY.
  - IDLE: key_valid -> LOAD. That byte goes to K[0] (and B[0]) and idx becomes 1.
  - LOAD: each key_valid beat writes K[idx] (and B[idx]) and increments idx. A cycle without key_valid holds; there is no timeout. The write at idx=15 moves to READY with idx=0, round=0, rcon=0x01.
  - READY: each data_valid beat does the following in the same cycle:
    - out byte = data_in ^ K[idx];
    - K[idx] <= N(idx);
    - idx <= idx+1, wrapping 15 -> 0.
- Next-key byte N(i), using current register values:
  - i = 0..3: K[i] ^ S(K[12+((i+1) mod 4)]) ^ (i==0 ? rcon : 0).
  - i = 4..15: K[i] ^ K[i-4]. K[i-4] has already been overwritten with its new value in an earlier beat.
  - Column 3 is still unmodified while i = 0..3 use it. Exactly one S-box (sub_bytes, mode 0) is needed; its input mux is selected by idx[1:0].
- At idx=15 of a round:
  - if round < NR: round_done = 1, round increments, rcon <= xtime(rcon) (poly 0x11B, so 0x80 -> 0x1B).
  - if round == NR: round_done = 1 and block_done = 1.
    - KEEP_KEY=1: K <= B, round = 0, rcon = 0x01, stay in READY.
    - KEEP_KEY=0: go to IDLE with round = 0.
- Latency: data_out and data_out_valid appear exactly 1 cycle after the accepted data_valid beat. round_done and block_done are aligned with data_out_valid.
- Back-pressure: none. Gaps in data_valid are allowed; idx and K hold during gaps.
- data_valid in IDLE or LOAD is ignored; data_out_valid stays 0.
- key_valid in READY aborts the block. That byte loads K[0]; idx = 1, round = 0, rcon = 0x01, state = LOAD. A simultaneous data_valid is ignored, so key_valid has priority.
- rst at any time returns all state to its reset values on the next evaluation, independent of clk.
- round never exceeds NR; idx wraps modulo 16.

Decomposition:
- Shared package aes_pkg holds:
  - the Nb·4 = 16 byte-count constant;
  - NR;
  - the xtime function;
  - the state encoding IDLE/LOAD/READY.
- Sub-module: reuse the existing sub_bytes with mode = 0 as the single S-box. No new sub-module.

Test Plan:
- Load key 2b7e1516 28aed2a6 abf71588 09cf4f3c, then feed 16 bytes 3243f6a8 885a308d 313198a2 e0370734 -> data_out = 193de3be a0f4e22b 9ac68d2a e9f84808, round_done on the 16th byte, round becomes 1.
- Same key, feed 16 zero bytes for rounds 0..10 -> round-1 output a0fafe17 88542cb1 23a33939 2a6c7605; round-10 output d014f9a8 c9ee2589 e13f0cc8 b6630ca6; block_done on the last byte.
- KEEP_KEY=1: after block_done, feed zeros again -> output equals the cipher key 2b7e1516…; round=0, key_ready stays 1. KEEP_KEY=0: key_ready=0 and data_valid produces no output.
- Random gaps inserted in both key_valid and data_valid -> outputs identical to the gap-free run, each exactly 1 cycle after its input beat.
- key_valid asserted together with data_valid at idx=7 of round 3 -> no data_out_valid for that beat; a fresh load follows; the following round-0 output matches the new key.
- rst asserted mid-round 5 between clock edges -> all outputs 0 immediately; key_ready=0; state IDLE.
